// File: rtl/serial_frame_tx.sv
// Purpose: frames a WIDTH-bit word as start bit, data bits, optional even parity on one serial line.
// Latency: start bit one cycle after accept, first data bit two cycles after accept.
// Backpressure: load_ready is high only in IDLE; load_valid is ignored while a frame is in flight.
module serial_frame_tx #(
    parameter int WIDTH     = 4,
    parameter int PARITY_EN = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PRELAST = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        DATA   = 2'd2,
        PARITY = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             parity_bit;

    logic             head_bit;
    logic [WIDTH-1:0] shreg_next;

    // Next bit to put on the line and the register after that bit is consumed
    always_comb begin
        head_bit   = 1'b0;
        shreg_next = '0;
        if (LSB_FIRST != 0) begin
            head_bit   = shreg[0];
            shreg_next = {1'b0, shreg[WIDTH-1:1]};
        end else begin
            head_bit   = shreg[WIDTH-1];
            shreg_next = {shreg[WIDTH-2:0], 1'b0};
        end
    end

    // Handshake status is a direct decode of the state
    always_comb begin
        load_ready = (state == IDLE);
        busy       = (state != IDLE);
    end

    // Frame sequencer; serial_out and done are registered alongside the state
    // so the line value always matches the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            parity_bit <= 1'b0;
            serial_out <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    serial_out <= 1'b0;
                    done       <= 1'b0;
                    if (load_valid) begin
                        state      <= START;
                        shreg      <= data_in;
                        parity_bit <= ^data_in;
                        cnt        <= '0;
                        serial_out <= 1'b1;
                    end
                end
                START: begin
                    // Leaving the start bit: first data bit goes out, counter stays at 0
                    state      <= DATA;
                    serial_out <= head_bit;
                    shreg      <= shreg_next;
                    done       <= 1'b0;
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state      <= PARITY;
                            serial_out <= parity_bit;
                            done       <= 1'b1;
                        end else begin
                            state      <= IDLE;
                            serial_out <= 1'b0;
                            done       <= 1'b0;
                        end
                    end else begin
                        serial_out <= head_bit;
                        shreg      <= shreg_next;
                        cnt        <= cnt + 1'b1;
                        // Without parity the last data bit is the final bit of the frame
                        done       <= (PARITY_EN == 0) && (cnt == CNT_PRELAST);
                    end
                end
                PARITY: begin
                    state      <= IDLE;
                    serial_out <= 1'b0;
                    done       <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three instances covering LSB/parity, MSB/parity and LSB/no-parity.
// A frame-list model predicts every line cycle; literal sequences pin the model.
// Inputs change mid-cycle; outputs are sampled 2 time units after the rising edge.
module tb_serial_frame_tx;

    localparam int N = 3;
    localparam int PEN [N] = '{1, 1, 0};
    localparam int LSB [N] = '{1, 0, 1};

    logic             clk;
    logic             rst;
    logic [3:0]       din [N];
    logic [N-1:0]     vld;
    logic [N-1:0]     rdy;
    logic [N-1:0]     so;
    logic [N-1:0]     bsy;
    logic [N-1:0]     dn;

    int errors;
    int checks;

    // model: the bits of the current frame and how far along the line is
    logic [7:0] fbits [N];
    int         flen  [N];
    int         fpos  [N];

    // observed history, newest bit in position 0
    logic [31:0] hs [N];
    logic [31:0] hd [N];
    logic [3:0]  ds0;

    serial_frame_tx #(.WIDTH(4), .PARITY_EN(1), .LSB_FIRST(1)) u0 (
        .clk(clk), .rst(rst), .data_in(din[0]), .load_valid(vld[0]),
        .load_ready(rdy[0]), .serial_out(so[0]), .busy(bsy[0]), .done(dn[0]));
    serial_frame_tx #(.WIDTH(4), .PARITY_EN(1), .LSB_FIRST(0)) u1 (
        .clk(clk), .rst(rst), .data_in(din[1]), .load_valid(vld[1]),
        .load_ready(rdy[1]), .serial_out(so[1]), .busy(bsy[1]), .done(dn[1]));
    serial_frame_tx #(.WIDTH(4), .PARITY_EN(0), .LSB_FIRST(1)) u2 (
        .clk(clk), .rst(rst), .data_in(din[2]), .load_valid(vld[2]),
        .load_ready(rdy[2]), .serial_out(so[2]), .busy(bsy[2]), .done(dn[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs held during the ending cycle
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                flen[i] = 0;
                fpos[i] = 0;
            end else if (fpos[i] < flen[i]) begin
                fpos[i] = fpos[i] + 1;
            end else if (vld[i]) begin
                fbits[i] = '0;
                fbits[i][0] = 1'b1;
                for (int k = 0; k < 4; k++)
                    fbits[i][1+k] = (LSB[i] != 0) ? din[i][k] : din[i][3-k];
                if (PEN[i] != 0)
                    fbits[i][5] = ^din[i];
                flen[i] = 5 + PEN[i];
                fpos[i] = 0;
            end
        end
    endtask

    // One clock: update model at the edge, compare all outputs, log history
    task automatic step();
        logic mb;
        @(posedge clk);
        model_edge();
        #2;
        for (int i = 0; i < N; i++) begin
            mb = (fpos[i] < flen[i]);
            chk("serial_out", i, {31'd0, so[i]}, {31'd0, mb ? fbits[i][fpos[i]] : 1'b0});
            chk("done", i, {31'd0, dn[i]}, {31'd0, mb && (fpos[i] == flen[i] - 1)});
            chk("load_ready", i, {31'd0, rdy[i]}, {31'd0, !mb});
            chk("busy", i, {31'd0, bsy[i]}, {31'd0, mb});
            hs[i] = {hs[i][30:0], so[i]};
            hd[i] = {hd[i][30:0], dn[i]};
        end
        ds0 = {so[0], ds0[3:1]};
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ds0    = '0;
        for (int i = 0; i < N; i++) begin
            flen[i]  = 0;
            fpos[i]  = 0;
            fbits[i] = '0;
            hs[i]    = '0;
            hd[i]    = '0;
            din[i]   = 4'hF;
        end
        // Reset held with an offered word: nothing may start
        rst = 1'b1;
        vld = '1;
        repeat (5) step();
        for (int i = 0; i < N; i++) begin
            chk("reset_line", i, {27'd0, hs[i][4:0]}, 32'd0);
            chk("reset_done", i, {27'd0, hd[i][4:0]}, 32'd0);
        end
        rst = 1'b0;
        vld = '0;
        step();

        // Basic frame, LSB first with parity
        din[0] = 4'b1011;
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        repeat (4) step();
        chk("downstream_reg", 0, {28'd0, ds0}, 32'b1011);
        repeat (2) step();
        chk("basic_seq", 0, {25'd0, hs[0][6:0]}, 32'b1110110);
        chk("basic_done", 0, {25'd0, hd[0][6:0]}, 32'b0000010);

        // MSB first with parity
        din[1] = 4'b0110;
        vld[1] = 1'b1;
        step();
        vld[1] = 1'b0;
        repeat (6) step();
        chk("msb_seq", 1, {25'd0, hs[1][6:0]}, 32'b1011000);
        chk("msb_done", 1, {25'd0, hd[1][6:0]}, 32'b0000010);

        // Held valid with data changing mid-frame, then back-to-back
        din[0] = 4'hA;
        vld[0] = 1'b1;
        step();
        din[0] = 4'h5;
        repeat (7) step();
        vld[0] = 1'b0;
        repeat (6) step();
        chk("b2b_seq", 0, {18'd0, hs[0][13:0]}, 32'b10101001101000);
        chk("b2b_done", 0, {18'd0, hd[0][13:0]}, 32'b00000100000010);

        // Reset during the second data bit, then a clean frame
        din[0] = 4'hF;
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("abort_line", 0, {31'd0, so[0]}, 32'd0);
        rst = 1'b0;
        din[0] = 4'b0001;
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        repeat (6) step();
        chk("abort_seq", 0, {21'd0, hs[0][10:0]}, 32'b11101100010);
        chk("abort_done", 0, {21'd0, hd[0][10:0]}, 32'b00000000010);

        // No parity
        din[2] = 4'b1000;
        vld[2] = 1'b1;
        step();
        vld[2] = 1'b0;
        repeat (5) step();
        chk("nopar_seq", 2, {26'd0, hs[2][5:0]}, 32'b100010);
        chk("nopar_done", 2, {26'd0, hd[2][5:0]}, 32'b000010);
        chk("nopar_ready", 2, {31'd0, rdy[2]}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Parallel-to-serial frame transmitter that feeds the team's 4-bit shift-right register stage. It accepts a WIDTH-bit word over a valid/ready handshake and drives it one bit per clock on a single serial line as a framed sequence: a start bit, then the data bits, then an optional even-parity bit. It returns to an idle-low line between frames. The downstream shift register samples `serial_out` on its `d_in` each clock.

## Interface
- `WIDTH`, default 4: data word width; legal range 2..16.
- `PARITY_EN`, default 1: 1 appends an even-parity bit after the data; 0 omits it.
- `LSB_FIRST`, default 1: 1 sends bit 0 first; 0 sends bit WIDTH-1 first.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `data_in`  in  WIDTH: word to transmit; sampled only on the accept edge.
- `load_valid`  in  1: upstream offers `data_in`.
- `load_ready`  out  1: block can accept; equals (state == IDLE), combinational from state.
- `serial_out`  out  1: registered serial line to the downstream stage.
- `busy`  out  1: equals ~`load_ready`.
- `done`  out  1: registered; one-cycle pulse during the final bit of a frame.

## Operation
- FSM states and transitions:
  - IDLE: on accept, go to START.
  - START: go to DATA.
  - DATA: stay for exactly WIDTH cycles; then go to PARITY if `PARITY_EN`=1, else to IDLE.
  - PARITY: go to IDLE.
- Accept: on a rising edge with `load_valid`=1 and `load_ready`=1.
  - Capture `data_in` into the internal shift register.
  - Compute the parity bit = XOR of all captured bits, so that data plus parity together have an even number of ones.
  - Clear the bit counter.
- `load_valid` is ignored outside IDLE. A held or changed `data_in` has no effect on the frame in flight.
- Line value by state:
  - IDLE: `serial_out`=0.
  - START: `serial_out`=1.
  - DATA: the current data bit, in the order set by `LSB_FIRST`.
  - PARITY: the parity bit.
- Bit counter width: $clog2(WIDTH+1). It counts 0..WIDTH-1 in DATA and does not wrap past WIDTH-1.
- `done`=1 during the last bit cycle: the PARITY cycle, or the last DATA cycle when `PARITY_EN`=0. `done`=0 in every other cycle.
- Reset values: state=IDLE, `serial_out`=0, `done`=0, `load_ready`=1, `busy`=0, counter=0, shift register=0.
- Reset mid-frame: the frame is aborted and the data is discarded. On the next cycle `serial_out`=0 and no `done` pulse is produced.
- Reset takes priority over a simultaneous accept: that word is not captured.

## Timing
- Define E0 as the accept edge and cycle k as the cycle after edge E0+k-1.
  - Cycle 1: start bit.
  - Cycles 2..WIDTH+1: data bits.
  - Cycle WIDTH+2: parity bit, when enabled.
- Frame length on the line: WIDTH+1+`PARITY_EN` cycles.
- After the final bit, the block spends at least one IDLE cycle with `serial_out`=0 and `load_ready`=1. The earliest next accept is at the end of that cycle.
  - Back-to-back throughput: one word per WIDTH+2+`PARITY_EN` cycles.
- Latency from accept to the first data bit on `serial_out`: 2 cycles.
- `load_ready` falls in the cycle immediately after the accept edge and rises in the first IDLE cycle.

## Test plan
- Reset: hold `rst`=1 for 5 cycles while `load_valid`=1, `data_in`=4'hF. Required: `serial_out`=0, `done`=0, `load_ready`=1 throughout; no frame starts.
- Basic frame (WIDTH=4, PARITY_EN=1, LSB_FIRST=1): accept 4'b1011. Required:
  - `serial_out` sequence 1,1,1,0,1,1, then 0.
  - `done` high only on the 6th bit.
  - A downstream 4-bit shift-right register ends holding the data bits in arrival order.
- Parity and order (PARITY_EN=1, LSB_FIRST=0): accept 4'b0110. Required: sequence 1,0,1,1,0,0, then 0. The parity bit is 0 because the word has two ones.
- Busy-ignore / back-to-back: keep `load_valid`=1 and change `data_in` from 4'hA to 4'h5 mid-frame. Required:
  - The frame carries 4'hA.
  - Exactly one IDLE cycle follows, then the 4'h5 frame starts.
- Reset mid-frame: assert `rst` for 1 cycle during the 2nd data bit. Required:
  - `serial_out`=0 on the next cycle.
  - No `done` pulse.
  - A subsequent accept of 4'b0001 produces 1,1,0,0,0,1.
- No-parity (PARITY_EN=0): accept 4'b1000. Required: sequence 1,0,0,0,1 with `done` on the last bit, then `load_ready`=1.
